// File: rtl/reflet_bus_map_pkg.sv
// Shared types and constants for the Reflet bus map: read-steering selector,
// fault counter width and its saturating increment.
package reflet_bus_map_pkg;

    localparam int FAULT_CNT_W = 8;
    localparam int MAX_SLAVES  = 16;
    localparam int IDX_W       = 4;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } sel_t;

    function automatic logic [FAULT_CNT_W-1:0] sat_inc(input logic [FAULT_CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/reflet_bus_decode.sv
// Combinational priority address decoder: lowest-index matching region wins,
// and the offset is the address bits below that region's size.
module reflet_bus_decode
    import reflet_bus_map_pkg::*;
#(
    parameter int                            wordsize        = 16,
    parameter int                            nb_slaves       = 4,
    parameter logic [nb_slaves*wordsize-1:0] slave_base      = '0,
    parameter logic [nb_slaves*8-1:0]        slave_size_log2 = '0
) (
    input  logic [wordsize-1:0] addr_i,
    output logic                hit_o,
    output logic [IDX_W-1:0]    hit_idx_o,
    output logic [wordsize-1:0] offset_o
);

    logic [nb_slaves-1:0] match;
    logic [wordsize-1:0]  off_arr [nb_slaves];

    // Comparing only the bits above the region size is the same as comparing
    // the shifted address and base; a full-width size yields an all-ones mask.
    for (genvar g = 0; g < nb_slaves; g++) begin : g_region
        localparam logic [wordsize-1:0] BASE = slave_base[g*wordsize +: wordsize];
        localparam int                  SZ   = int'(slave_size_log2[g*8 +: 8]);
        localparam logic [wordsize-1:0] MASK = (SZ >= wordsize) ? {wordsize{1'b1}}
                                                                : ~({wordsize{1'b1}} << SZ);
        assign match[g]   = ((addr_i & ~MASK) == (BASE & ~MASK));
        assign off_arr[g] = addr_i & MASK;
    end

    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        offset_o  = '0;
        for (int i = nb_slaves - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_o     = 1'b1;
                hit_idx_o = IDX_W'(i);
                offset_o  = off_arr[i];
            end
        end
    end

endmodule

// File: rtl/reflet_bus_map.sv
// Address decoder and registered read-data mux between a reflet_cpu master and
// nb_slaves memory-mapped slaves, with sticky fault reporting.
module reflet_bus_map
    import reflet_bus_map_pkg::*;
#(
    parameter int                            wordsize        = 16,
    parameter int                            nb_slaves       = 4,
    parameter logic [nb_slaves*wordsize-1:0] slave_base      = '0,
    parameter logic [nb_slaves*8-1:0]        slave_size_log2 = '0,
    parameter logic [nb_slaves-1:0]          read_only       = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [wordsize-1:0]           cpu_addr,
    input  logic [wordsize-1:0]           cpu_data_out,
    input  logic                          cpu_write_en,
    output logic [wordsize-1:0]           cpu_data_in,
    output logic [nb_slaves-1:0]          slave_enable,
    output logic [nb_slaves-1:0]          slave_write_en,
    output logic [wordsize-1:0]           slave_addr,
    output logic [wordsize-1:0]           slave_data_out,
    input  logic [nb_slaves*wordsize-1:0] slave_data_in,
    input  logic                          fault_clear,
    output logic                          fault,
    output logic [wordsize-1:0]           fault_addr,
    output logic [FAULT_CNT_W-1:0]        fault_count
);

    logic                   dec_hit;
    logic [IDX_W-1:0]       dec_idx;
    logic [wordsize-1:0]    dec_off;
    logic [MAX_SLAVES-1:0]  ro_ext;
    logic                   fault_evt;

    sel_t                   sel_q, sel_d;
    logic                   fault_q, fault_d;
    logic [wordsize-1:0]    fault_addr_q, fault_addr_d;
    logic [FAULT_CNT_W-1:0] fault_cnt_q, fault_cnt_d;

    reflet_bus_decode #(
        .wordsize        (wordsize),
        .nb_slaves       (nb_slaves),
        .slave_base      (slave_base),
        .slave_size_log2 (slave_size_log2)
    ) u_decode (
        .addr_i    (cpu_addr),
        .hit_o     (dec_hit),
        .hit_idx_o (dec_idx),
        .offset_o  (dec_off)
    );

    assign ro_ext = MAX_SLAVES'(read_only);

    always_comb begin
        slave_enable = '0;
        for (int i = 0; i < nb_slaves; i++) begin
            slave_enable[i] = dec_hit && (dec_idx == IDX_W'(i));
        end
    end

    assign slave_write_en = {nb_slaves{cpu_write_en}} & slave_enable & ~read_only;
    assign slave_addr     = dec_off;
    assign slave_data_out = cpu_data_out;

    // The selector is captured every cycle so the mux tracks synchronous-read slaves.
    assign sel_d = '{valid: dec_hit, idx: dec_idx};

    always_comb begin
        cpu_data_in = '0;
        for (int i = 0; i < nb_slaves; i++) begin
            if (sel_q.valid && (sel_q.idx == IDX_W'(i))) begin
                cpu_data_in = slave_data_in[i*wordsize +: wordsize];
            end
        end
    end

    assign fault_evt = !dec_hit || (cpu_write_en && ro_ext[dec_idx]);

    // A fault in the same cycle as a clear wins and re-arms the address capture.
    always_comb begin
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        fault_cnt_d  = fault_cnt_q;
        if (fault_clear) begin
            fault_d      = 1'b0;
            fault_addr_d = '0;
        end
        if (fault_evt) begin
            fault_d     = 1'b1;
            fault_cnt_d = sat_inc(fault_cnt_q);
            if (!fault_q || fault_clear) begin
                fault_addr_d = cpu_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q        <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            fault_cnt_q  <= '0;
        end else begin
            sel_q        <= sel_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            fault_cnt_q  <= fault_cnt_d;
        end
    end

    assign fault       = fault_q;
    assign fault_addr  = fault_addr_q;
    assign fault_count = fault_cnt_q;

endmodule

// File: tb/tb_reflet_bus_map.sv
// Bench for reflet_bus_map: range-based decode model, read-data scoreboard
// and a fault-register model, driven from directed and random cycles.
module tb_reflet_bus_map;
    import reflet_bus_map_pkg::*;

    localparam int W = 16;
    localparam int N = 4;

    logic            clk;
    logic            reset;
    logic [W-1:0]    cpu_addr;
    logic [W-1:0]    cpu_data_out;
    logic            cpu_write_en;
    logic [W-1:0]    cpu_data_in;
    logic [N-1:0]    slave_enable;
    logic [N-1:0]    slave_write_en;
    logic [W-1:0]    slave_addr;
    logic [W-1:0]    slave_data_out;
    logic [N*W-1:0]  slave_data_in;
    logic            fault_clear;
    logic            fault;
    logic [W-1:0]    fault_addr;
    logic [7:0]      fault_count;

    reflet_bus_map #(
        .wordsize        (W),
        .nb_slaves       (N),
        .slave_base      ({16'hF000, 16'h8000, 16'h4000, 16'h0000}),
        .slave_size_log2 ({8'd8, 8'd12, 8'd14, 8'd14}),
        .read_only       (4'b0001)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_addr       (cpu_addr),
        .cpu_data_out   (cpu_data_out),
        .cpu_write_en   (cpu_write_en),
        .cpu_data_in    (cpu_data_in),
        .slave_enable   (slave_enable),
        .slave_write_en (slave_write_en),
        .slave_addr     (slave_addr),
        .slave_data_out (slave_data_out),
        .slave_data_in  (slave_data_in),
        .fault_clear    (fault_clear),
        .fault          (fault),
        .fault_addr     (fault_addr),
        .fault_count    (fault_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard and model state
    logic [W-1:0]   exp_q[$];
    logic [N*W-1:0] next_sd;
    int             m_base [N];
    int             m_size [N];
    logic           m_fault;
    logic [W-1:0]   m_fault_addr;
    int             m_cnt;
    int             n_cmp;
    int             n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_dec(input logic [W-1:0] a, output logic hit,
                                      output int idx, output logic [W-1:0] off);
        int ai;
        ai  = int'(a);
        hit = 1'b0;
        idx = 0;
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (ai >= m_base[i] && ai < m_base[i] + m_size[i]) begin
                hit = 1'b1;
                idx = i;
                off = W'(ai - m_base[i]);
            end
        end
    endfunction

    // One bus cycle, starting 1 time unit after a rising edge.
    task automatic do_cycle(input logic [W-1:0] a, input logic we,
                            input logic [W-1:0] wd, input logic clr);
        logic         hit;
        int           idx;
        logic [W-1:0] off;
        logic [N-1:0] exp_en;
        logic         evt;
        logic [W-1:0] got_rd;
        cpu_addr      = a;
        cpu_write_en  = we;
        cpu_data_out  = wd;
        fault_clear   = clr;
        slave_data_in = next_sd;
        #3;
        model_dec(a, hit, idx, off);
        exp_en = hit ? N'(1 << idx) : '0;
        check("slave_enable", 32'(slave_enable), 32'(exp_en));
        check("slave_addr", 32'(slave_addr), 32'(off));
        check("slave_write_en", 32'(slave_write_en), 32'((we && idx != 0) ? exp_en : '0));
        check("slave_data_out", 32'(slave_data_out), 32'(wd));
        got_rd = cpu_data_in;
        if (exp_q.size() == 0) begin
            check("rd_queue_empty", 32'(1), 32'(0));
        end else begin
            check("cpu_data_in", 32'(got_rd), 32'(exp_q.pop_front()));
        end
        next_sd = {$urandom(), $urandom()};
        exp_q.push_back(hit ? next_sd[idx*W +: W] : '0);
        evt = !hit || (we && idx == 0);
        if (evt) begin
            if (!m_fault || clr) m_fault_addr = a;
            m_fault = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end else if (clr) begin
            m_fault      = 1'b0;
            m_fault_addr = '0;
        end
        @(posedge clk);
        #1;
        check("fault", 32'(fault), 32'(m_fault));
        check("fault_addr", 32'(fault_addr), 32'(m_fault_addr));
        check("fault_count", 32'(fault_count), 32'(m_cnt));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_base = '{32'h0000, 32'h4000, 32'h8000, 32'hF000};
        m_size = '{16384, 16384, 4096, 256};
        m_fault = 1'b0;
        m_fault_addr = '0;
        m_cnt = 0;
        next_sd = {$urandom(), $urandom()};

        reset         = 1'b0;
        cpu_addr      = 16'h4123;
        cpu_data_out  = '0;
        cpu_write_en  = 1'b0;
        fault_clear   = 1'b0;
        slave_data_in = next_sd;
        @(posedge clk);
        #1;
        check("rst_cpu_data_in", 32'(cpu_data_in), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_fault_addr", 32'(fault_addr), 32'h0);
        check("rst_fault_count", 32'(fault_count), 32'h0);
        check("rst_decode_enable", 32'(slave_enable), 32'h2);
        check("rst_decode_addr", 32'(slave_addr), 32'h0123);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.push_back('0);

        // reads back to back, then a write to RAM
        do_cycle(16'h4123, 1'b0, 16'h0, 1'b0);
        do_cycle(16'h0005, 1'b0, 16'h0, 1'b0);
        do_cycle(16'h8FFF, 1'b0, 16'h0, 1'b0);
        do_cycle(16'hF0AB, 1'b0, 16'h0, 1'b0);
        do_cycle(16'h4001, 1'b1, 16'h1234, 1'b0);

        // write to read-only ROM
        do_cycle(16'h0010, 1'b1, 16'hBEEF, 1'b0);
        check("ro_fault_addr", 32'(fault_addr), 32'h0010);
        check("ro_fault_count", 32'(fault_count), 32'd1);

        // clear, then unmapped accesses
        do_cycle(16'h4000, 1'b0, 16'h0, 1'b1);
        check("clear_fault", 32'(fault), 32'h0);
        do_cycle(16'hA000, 1'b0, 16'h0, 1'b0);
        do_cycle(16'hC000, 1'b0, 16'h0, 1'b0);
        check("first_fault_addr_kept", 32'(fault_addr), 32'hA000);

        // saturation
        for (int i = 0; i < 300; i++) do_cycle(16'hA000 + 16'(i), 1'b0, 16'h0, 1'b0);
        check("count_saturated", 32'(fault_count), 32'd255);

        // clear colliding with a fault, then a clean clear
        do_cycle(16'hB000, 1'b0, 16'h0, 1'b1);
        check("clear_vs_fault_flag", 32'(fault), 32'h1);
        check("clear_vs_fault_addr", 32'(fault_addr), 32'hB000);
        do_cycle(16'h8000, 1'b0, 16'h0, 1'b1);
        check("clear_keeps_count", 32'(fault_count), 32'd255);

        // random traffic
        for (int i = 0; i < 60; i++) begin
            do_cycle(16'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 1)),
                     16'($urandom()), 1'($urandom_range(0, 7) == 0));
        end

        // reset mid-read with 0x4000 pending
        do_cycle(16'h4000, 1'b0, 16'h0, 1'b0);
        slave_data_in = next_sd;
        reset = 1'b0;
        #1;
        check("midrst_cpu_data_in", 32'(cpu_data_in), 32'h0);
        check("midrst_fault", 32'(fault), 32'h0);
        check("midrst_fault_addr", 32'(fault_addr), 32'h0);
        check("midrst_fault_count", 32'(fault_count), 32'h0);
        void'(exp_q.pop_front());
        m_fault = 1'b0;
        m_fault_addr = '0;
        m_cnt = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.push_back('0);
        do_cycle(16'h4000, 1'b0, 16'h0, 1'b0);
        do_cycle(16'h8123, 1'b0, 16'h0, 1'b0);
        do_cycle(16'hE000, 1'b0, 16'h0, 1'b0);
        do_cycle(16'h0001, 1'b0, 16'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
